// File: rtl/noc_agu_pkg.sv
// noc_agu_pkg: shared types and routing helper for the mesh-router address
// generation unit (agu_wormhole).
//   flit_type_e  : 2-bit flit type carried in the top two bits of every flit
//   P_N..P_L     : fixed port order, also the bit order of one-hot routes
//   coord_t      : zero-extended {x,y} position used by route_onehot
//   route_onehot : dimension-ordered route, XY by default
// Build option: define AGU_YX_ROUTE_EN to resolve Y before X (YX order).
package noc_agu_pkg;

  localparam int unsigned NP      = 5;
  localparam int unsigned P_N     = 0;
  localparam int unsigned P_S     = 1;
  localparam int unsigned P_E     = 2;
  localparam int unsigned P_W     = 3;
  localparam int unsigned P_L     = 4;
  // Widest coordinate the routing helper handles; narrower fields are zero-extended.
  localparam int unsigned COORD_W = 16;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // One-hot output port for a destination, compared as unsigned positions.
  function automatic logic [NP-1:0] route_onehot(input coord_t dest, input coord_t myaddr);
    logic [NP-1:0] r;
    r = '0;
`ifdef AGU_YX_ROUTE_EN
    if (dest.y > myaddr.y)      r[P_N] = 1'b1;
    else if (dest.y < myaddr.y) r[P_S] = 1'b1;
    else if (dest.x > myaddr.x) r[P_E] = 1'b1;
    else if (dest.x < myaddr.x) r[P_W] = 1'b1;
    else                        r[P_L] = 1'b1;
`else
    if (dest.x > myaddr.x)      r[P_E] = 1'b1;
    else if (dest.x < myaddr.x) r[P_W] = 1'b1;
    else if (dest.y > myaddr.y) r[P_N] = 1'b1;
    else if (dest.y < myaddr.y) r[P_S] = 1'b1;
    else                        r[P_L] = 1'b1;
`endif
    return r;
  endfunction

endpackage

// File: rtl/agu_port_fsm.sv
// agu_port_fsm: route latch, wormhole lock and sticky error for one input port.
//   clk, rst : clock, synchronous active-high reset
//   myaddr   : router {x,y}
//   valid    : queue-head flit valid
//   flit     : queue-head flit
//   ready    : pop strobe (combinational from state, valid, flit type, grant)
//   req      : registered one-hot output-port request
//   grant    : allocator grant for the locked route
//   err      : sticky protocol error (stray body/tail, nested head, U-turn)
module agu_port_fsm
  import noc_agu_pkg::*;
#(
  parameter int unsigned X_W      = 3,
  parameter int unsigned Y_W      = 3,
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned PORT_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_W+Y_W-1:0]   myaddr,
  input  logic                 valid,
  input  logic [FLIT_W-1:0]    flit,
  output logic                 ready,
  output logic [NP-1:0]        req,
  input  logic                 grant,
  output logic                 err
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e        state;
  logic [NP-1:0] route_q;
  logic          first_done;
  logic          err_q;

  flit_type_e    ftype;
  logic          is_head;
  logic          is_tail;
  coord_t        dest;
  coord_t        me;
  logic [NP-1:0] route_c;
  logic          ready_c;
  logic          accept;
  logic          flit_unused;

  // Payload bits between type and destination do not affect routing.
  assign flit_unused = ^flit[FLIT_W-3:X_W+Y_W];

  assign ftype   = flit_type_e'(flit[FLIT_W-1 -: 2]);
  assign is_head = (ftype == HEAD) || (ftype == HEAD_TAIL);
  assign is_tail = (ftype == TAIL) || (ftype == HEAD_TAIL);

  assign dest.x  = COORD_W'(flit[X_W+Y_W-1:Y_W]);
  assign dest.y  = COORD_W'(flit[Y_W-1:0]);
  assign me.x    = COORD_W'(myaddr[X_W+Y_W-1:Y_W]);
  assign me.y    = COORD_W'(myaddr[Y_W-1:0]);
  assign route_c = route_onehot(dest, me);

  // Pop: stray body/tail is dropped in IDLE; heads wait for the route cycle.
  always_comb begin
    ready_c = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    ready_c = valid & ~is_head;
        ACTIVE:  ready_c = grant;
        default: ready_c = 1'b0;
      endcase
    end
  end

  assign accept = valid & ready_c;

  // State, route latch and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      route_q    <= '0;
      first_done <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            if (is_head) begin
              state      <= ACTIVE;
              route_q    <= route_c;
              first_done <= 1'b0;
              if (route_c[PORT_IDX]) err_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (accept) begin
            first_done <= 1'b1;
            // The first accepted flit is the routing head; any later head is nested.
            if (first_done && is_head) err_q <= 1'b1;
            if (is_tail) begin
              state   <= IDLE;
              route_q <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = ready_c;
  assign req   = route_q;
  assign err   = err_q;

endmodule

// File: rtl/agu_wormhole.sv
// agu_wormhole: per-input dimension-ordered route generation with wormhole
// lock, placed between the input queues and the switch allocator.
//   clk, rst     : clock, synchronous active-high reset
//   myaddr_i     : router {x,y}, static after reset
//   in_valid_i   : per-input flit valid
//   in_flit_i    : per-input queue-head flit, port p at [p*FLIT_W +: FLIT_W]
//   in_ready_o   : per-input pop strobe
//   req_o        : per-input one-hot output request, input p at [p*NP +: NP]
//   grant_i      : per-input grant for the locked route
//   err_o        : per-input sticky protocol error
// Build option: AGU_YX_ROUTE_EN selects YX dimension order (default XY).
module agu_wormhole
  import noc_agu_pkg::*;
#(
  parameter int unsigned X_W    = 3,
  parameter int unsigned Y_W    = 3,
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned NP     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_W+Y_W-1:0]   myaddr_i,
  input  logic [NP-1:0]        in_valid_i,
  input  logic [NP*FLIT_W-1:0] in_flit_i,
  output logic [NP-1:0]        in_ready_o,
  output logic [NP*NP-1:0]     req_o,
  input  logic [NP-1:0]        grant_i,
  output logic [NP-1:0]        err_o
);

  // Port order and one-hot layout are fixed to the five-port mesh router.
  if (NP != noc_agu_pkg::NP) begin : g_bad_np
    $error("agu_wormhole supports only NP == 5");
  end
  if ((X_W + Y_W + 2 > FLIT_W) || (X_W > COORD_W) || (Y_W > COORD_W)) begin : g_bad_w
    $error("agu_wormhole: coordinate fields do not fit the flit");
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    agu_port_fsm #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .FLIT_W   (FLIT_W),
      .PORT_IDX (p)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .myaddr (myaddr_i),
      .valid  (in_valid_i[p]),
      .flit   (in_flit_i[p*FLIT_W +: FLIT_W]),
      .ready  (in_ready_o[p]),
      .req    (req_o[p*NP +: NP]),
      .grant  (grant_i[p]),
      .err    (err_o[p])
    );
  end

endmodule

// File: tb/tb_agu_wormhole.sv
// tb_agu_wormhole: directed self-checking bench for agu_wormhole with the
// router at (2,2). Inputs change on the falling edge; outputs are sampled
// 1 time unit later, well before the next rising edge.
module tb_agu_wormhole;

  localparam int unsigned FW = 32;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_E = 5'b00100;
  localparam logic [4:0] R_W = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  logic          clk;
  logic          rst;
  logic [5:0]    myaddr;
  logic [4:0]    in_valid;
  logic [5*FW-1:0] in_flit;
  logic [4:0]    in_ready;
  logic [24:0]   req;
  logic [4:0]    grant;
  logic [4:0]    err;

  int n_cmp = 0;
  int n_mis = 0;

  agu_wormhole dut (
    .clk        (clk),
    .rst        (rst),
    .myaddr_i   (myaddr),
    .in_valid_i (in_valid),
    .in_flit_i  (in_flit),
    .in_ready_o (in_ready),
    .req_o      (req),
    .grant_i    (grant),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y);
    return {t, 24'h00_0000, x, y};
  endfunction

  task automatic drive(input int p, input logic v, input logic [FW-1:0] f, input logic g);
    in_valid[p]          = v;
    in_flit[p*FW +: FW]  = f;
    grant[p]             = g;
  endtask

  // Route sweep on the W input.
  logic [2:0] sx   [5] = '{3'd5, 3'd0, 3'd2, 3'd2, 3'd2};
  logic [2:0] sy   [5] = '{3'd0, 3'd5, 3'd6, 3'd1, 3'd2};
`ifdef AGU_YX_ROUTE_EN
  logic [4:0] sexp [5] = '{R_S, R_N, R_N, R_S, R_L};
  localparam logic [4:0] SWEEP_ERR = 5'b00000;
  localparam logic [4:0] W_HEAD50  = R_S;
  localparam logic [24:0] CONC_REQ = {R_N, R_S, R_S, R_N, R_E};
`else
  logic [4:0] sexp [5] = '{R_E, R_W, R_N, R_S, R_L};
  localparam logic [4:0] SWEEP_ERR = 5'b01000;  // (0,5) on W input is a U-turn
  localparam logic [4:0] W_HEAD50  = R_E;
  localparam logic [24:0] CONC_REQ = {R_E, R_S, R_W, R_N, R_E};
`endif

  logic [FW-1:0] fl [4];
  logic          gp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0]    exp_err;
  int            idx;

  initial begin
    rst      = 1'b1;
    myaddr   = {3'd2, 3'd2};
    in_valid = '0;
    in_flit  = '0;
    grant    = '0;
    exp_err  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(req), 32'(0));
    check("rst_rdy", 32'(in_ready), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_rdy", 32'(in_ready), 32'(0));

    // Route sweep on W input.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(3, 1'b1, mk(T_HT, sx[i], sy[i]), 1'b0);
      #1;
      check("sweep_hold", 32'(in_ready[3]), 32'(0));
      check("sweep_req0", 32'(req[15 +: 5]), 32'(0));
      @(negedge clk);
      grant[3] = 1'b1;
      #1;
      check("sweep_req", 32'(req[15 +: 5]), 32'(sexp[i]));
      check("sweep_pop", 32'(in_ready[3]), 32'(1));
      @(negedge clk);
      drive(3, 1'b0, '0, 1'b0);
      #1 check("sweep_clr", 32'(req[15 +: 5]), 32'(0));
    end
    exp_err = SWEEP_ERR;
    check("sweep_err", 32'(err), 32'(exp_err));

    // Wormhole lock on N input; body payloads look like other destinations.
    fl[0] = mk(T_HEAD, 3'd4, 3'd2);
    fl[1] = mk(T_BODY, 3'd0, 3'd0);
    fl[2] = mk(T_BODY, 3'd7, 3'd7);
    fl[3] = mk(T_TAIL, 3'd0, 3'd0);
    @(negedge clk);
    drive(0, 1'b1, fl[0], 1'b1);
    #1 check("wh_hold", 32'(in_ready[0]), 32'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 1'b1, fl[k], 1'b1);
      #1;
      check("wh_req", 32'(req[0 +: 5]), 32'(R_E));
      check("wh_pop", 32'(in_ready[0]), 32'(1));
    end
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    #1 check("wh_clr", 32'(req[0 +: 5]), 32'(0));

    // Nested head on N input: error, lock kept.
    @(negedge clk);
    drive(0, 1'b1, mk(T_HEAD, 3'd4, 3'd2), 1'b1);
    @(negedge clk);
    #1 check("nest_pop_head", 32'(in_ready[0]), 32'(1));
    @(negedge clk);
    drive(0, 1'b1, mk(T_HEAD, 3'd1, 3'd1), 1'b1);
    @(negedge clk);
    drive(0, 1'b1, mk(T_TAIL, 3'd0, 3'd0), 1'b1);
    exp_err[0] = 1'b1;
    #1;
    check("nest_err", 32'(err), 32'(exp_err));
    check("nest_req", 32'(req[0 +: 5]), 32'(R_E));
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    #1 check("nest_clr", 32'(req[0 +: 5]), 32'(0));

    // Backpressure on L input.
    fl[0] = mk(T_HEAD, 3'd2, 3'd4);
    fl[1] = mk(T_BODY, 3'd5, 3'd5);
    fl[2] = mk(T_TAIL, 3'd1, 3'd1);
    idx = 0;
    @(negedge clk);
    drive(4, 1'b1, fl[0], 1'b0);
    #1 check("bp_hold", 32'(in_ready[4]), 32'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(4, 1'b1, fl[idx], gp[k]);
      #1;
      check("bp_rdy", 32'(in_ready[4]), 32'(gp[k]));
      check("bp_req", 32'(req[20 +: 5]), 32'(R_N));
      if (gp[k]) idx++;
    end
    @(negedge clk);
    drive(4, 1'b0, '0, 1'b0);
    #1 check("bp_clr", 32'(req[20 +: 5]), 32'(0));

    // Stray BODY on S input while idle.
    @(negedge clk);
    drive(1, 1'b1, mk(T_BODY, 3'd3, 3'd3), 1'b0);
    #1 check("stray_pop", 32'(in_ready[1]), 32'(1));
    @(negedge clk);
    drive(1, 1'b0, '0, 1'b0);
    exp_err[1] = 1'b1;
    #1 check("stray_err", 32'(err), 32'(exp_err));

    // U-turn on E input: route still issued.
    @(negedge clk);
    drive(2, 1'b1, mk(T_HT, 3'd5, 3'd2), 1'b0);
    #1 check("ut_hold", 32'(in_ready[2]), 32'(0));
    @(negedge clk);
    grant[2] = 1'b1;
    exp_err[2] = 1'b1;
    #1;
    check("ut_req", 32'(req[10 +: 5]), 32'(R_E));
    check("ut_err", 32'(err), 32'(exp_err));
    check("ut_pop", 32'(in_ready[2]), 32'(1));
    @(negedge clk);
    drive(2, 1'b0, '0, 1'b0);
    #1 check("ut_clr", 32'(req), 32'(0));

    // Reset mid-packet on W after two accepted flits.
    fl[0] = mk(T_HEAD, 3'd5, 3'd0);
    fl[1] = mk(T_BODY, 3'd0, 3'd0);
    fl[2] = mk(T_BODY, 3'd0, 3'd0);
    @(negedge clk);
    drive(3, 1'b1, fl[0], 1'b1);
    @(negedge clk);
    #1 check("mr_req", 32'(req[15 +: 5]), 32'(W_HEAD50));
    @(negedge clk);
    drive(3, 1'b1, fl[1], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(3, 1'b1, fl[2], 1'b1);
    #1 check("mr_rst_rdy", 32'(in_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(3, 1'b0, '0, 1'b0);
    exp_err = '0;
    #1;
    check("mr_req0", 32'(req), 32'(0));
    check("mr_rdy0", 32'(in_ready), 32'(0));
    check("mr_err0", 32'(err), 32'(exp_err));
    @(negedge clk);
    drive(3, 1'b1, mk(T_HT, 3'd2, 3'd0), 1'b0);
    #1 check("mr_new_hold", 32'(in_ready[3]), 32'(0));
    @(negedge clk);
    grant[3] = 1'b1;
    #1 check("mr_new_req", 32'(req[15 +: 5]), 32'(R_S));
    @(negedge clk);
    drive(3, 1'b0, '0, 1'b0);
    #1 check("mr_new_clr", 32'(req), 32'(0));

    // Concurrent heads on all five inputs.
    @(negedge clk);
    drive(0, 1'b1, mk(T_HT, 3'd4, 3'd2), 1'b0);
    drive(1, 1'b1, mk(T_HT, 3'd2, 3'd5), 1'b0);
    drive(2, 1'b1, mk(T_HT, 3'd0, 3'd0), 1'b0);
    drive(3, 1'b1, mk(T_HT, 3'd2, 3'd0), 1'b0);
    drive(4, 1'b1, mk(T_HT, 3'd5, 3'd6), 1'b0);
    #1 check("conc_hold", 32'(in_ready), 32'(0));
    @(negedge clk);
    grant = 5'b11111;
    #1;
    check("conc_req", 32'(req), 32'(CONC_REQ));
    check("conc_pop", 32'(in_ready), 32'(5'b11111));
    check("conc_err", 32'(err), 32'(exp_err));
    @(negedge clk);
    in_valid = '0;
    grant    = '0;
    #1 check("conc_clr", 32'(req), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
